// File: rtl/proc_gen.sv
// proc_gen: parametrised multicycle processor with a shared bus,
// 2^RB registers, four-step counter and registered carry/zero flags.
module proc_gen #(
  parameter int N  = 8,
  parameter int RB = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          w,
  input  logic [N-1:0]  Data,
  input  logic [2:0]    F,
  input  logic [RB-1:0] Rx,
  input  logic [RB-1:0] Ry,
  output logic [N-1:0]  BusWires,
  output logic          Done,
  output logic          Busy,
  output logic          Carry,
  output logic          Zero
);

  localparam int NR = 1 << RB;

  typedef enum logic [1:0] {
    T0, T1, T2, T3
  } step_t;

  step_t t, t_nx;

  logic [2:0]    f;
  logic [RB-1:0] rx, ry;
  logic [N-1:0]  rf [NR];
  logic [N-1:0]  a, g;

  logic          one_step;
  logic          ext, gout, rout;
  logic [RB-1:0] rsel;
  logic          a_ld, g_ld, rx_ld;

  logic [N:0]    sum;
  logic [N-1:0]  res;
  logic          c_nx;

  assign one_step = (f == 3'b000) || (f == 3'b001);
  assign Busy     = (t != T0);

  always_comb begin
    t_nx  = T0;
    Done  = 1'b0;
    ext   = 1'b0;
    gout  = 1'b0;
    rout  = 1'b0;
    rsel  = '0;
    a_ld  = 1'b0;
    g_ld  = 1'b0;
    rx_ld = 1'b0;
    unique case (t)
      T0: t_nx = w ? T1 : T0;
      T1: begin
        if (one_step) begin
          Done  = 1'b1;
          rx_ld = 1'b1;
          ext   = (f == 3'b001);
          rout  = (f == 3'b000);
          rsel  = ry;
        end else begin
          rout = 1'b1;
          rsel = rx;
          a_ld = 1'b1;
          t_nx = T2;
        end
      end
      T2: begin
        rout = 1'b1;
        rsel = ry;
        g_ld = 1'b1;
        t_nx = T3;
      end
      T3: begin
        gout  = 1'b1;
        rx_ld = 1'b1;
        Done  = 1'b1;
      end
    endcase
  end

  // Fixed driver priority keeps the bus single-sourced
  always_comb begin
    if (ext)       BusWires = Data;
    else if (gout) BusWires = g;
    else if (rout) BusWires = rf[rsel];
    else           BusWires = '0;
  end

  always_comb begin
    sum  = '0;
    res  = '0;
    c_nx = 1'b0;
    unique case (f)
      3'b000, 3'b001: begin
        res  = '0;
        c_nx = 1'b0;
      end
      3'b010: begin
        sum  = {1'b0, a} + {1'b0, BusWires};
        res  = sum[N-1:0];
        c_nx = sum[N];
      end
      3'b011: begin
        sum  = {1'b0, a} + {1'b0, ~BusWires} + (N+1)'(1);
        res  = sum[N-1:0];
        c_nx = sum[N];
      end
      3'b100: res = a & BusWires;
      3'b101: res = a | BusWires;
      3'b110: res = a ^ BusWires;
      3'b111: begin
        res  = {1'b0, a[N-1:1]};
        c_nx = a[0];
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      t     <= T0;
      f     <= '0;
      rx    <= '0;
      ry    <= '0;
      a     <= '0;
      g     <= '0;
      Carry <= 1'b0;
      Zero  <= 1'b0;
      for (int i = 0; i < NR; i++) rf[i] <= '0;
    end else begin
      t <= t_nx;
      if (t == T0 && w) begin
        f  <= F;
        rx <= Rx;
        ry <= Ry;
      end
      if (a_ld) a <= BusWires;
      if (g_ld) begin
        g     <= res;
        Carry <= c_nx;
        Zero  <= (res == '0);
      end
      if (rx_ld) rf[rx] <= BusWires;
    end
  end

endmodule

// File: tb/tb_proc_gen.sv
// tb_proc_gen: directed checks of proc_gen at N=8/RB=2 and N=16/RB=3
// with hand-computed bus sequences, register values and flags.
module tb_proc_gen;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        w;
  logic [15:0] Data;
  logic [2:0]  F;
  logic [2:0]  Rx, Ry;

  logic [7:0]  bus8;
  logic [15:0] bus16;
  logic        done8, busy8, c8, z8;
  logic        done16, busy16, c16, z16;

  int ncheck = 0;
  int npass  = 0;
  bit s16    = 1'b0;

  logic [15:0] bq[$];

  always #5 Clock = ~Clock;

  proc_gen #(.N(8), .RB(2)) dut8 (
    .Clock(Clock), .Reset(Reset), .w(w),
    .Data(Data[7:0]), .F(F), .Rx(Rx[1:0]), .Ry(Ry[1:0]),
    .BusWires(bus8), .Done(done8), .Busy(busy8),
    .Carry(c8), .Zero(z8)
  );

  proc_gen #(.N(16), .RB(3)) dut16 (
    .Clock(Clock), .Reset(Reset), .w(w),
    .Data(Data), .F(F), .Rx(Rx), .Ry(Ry),
    .BusWires(bus16), .Done(done16), .Busy(busy16),
    .Carry(c16), .Zero(z16)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncheck++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] bus();
    return s16 ? bus16 : {8'h00, bus8};
  endfunction
  function automatic logic done();
    return s16 ? done16 : done8;
  endfunction
  function automatic logic busy();
    return s16 ? busy16 : busy8;
  endfunction
  function automatic logic carry();
    return s16 ? c16 : c8;
  endfunction
  function automatic logic zero();
    return s16 ? z16 : z8;
  endfunction
  function automatic logic [15:0] rd(input logic [2:0] i);
    return s16 ? dut16.rf[i] : {8'h00, dut8.rf[i[1:0]]};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Issue one instruction, record bus per step, expect n steps
  task automatic run(input string tag, input logic [2:0] f,
                     input logic [2:0] x, input logic [2:0] y,
                     input logic [15:0] d, input int nexp);
    int  n;
    bit  bz;
    Reset = 1'b0;
    w = 1'b1; F = f; Rx = x; Ry = y; Data = d;
    step();
    w = 1'b0;
    n = -1;
    bz = 1'b1;
    bq.delete();
    for (int k = 1; k <= 6; k++) begin
      bq.push_back(bus());
      if (!busy()) bz = 1'b0;
      if (done()) begin
        n = k;
        break;
      end
      step();
    end
    step();
    check({tag, " steps"}, n, nexp);
    if (nexp > 1) check({tag, " busy"}, bz, 1'b1);
    check({tag, " idle"}, busy(), 1'b0);
  endtask

  task automatic mvi(input logic [2:0] x, input logic [15:0] d);
    run("mvi", 3'b001, x, 3'd0, d, 1);
  endtask

  task automatic abort_test(input logic [2:0] x, input logic [2:0] y,
                            input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] sum);
    mvi(x, va);
    mvi(y, vb);
    w = 1'b1; F = 3'b010; Rx = x; Ry = y;
    step();
    w = 1'b0;
    step();
    check("drop t2 busy", busy(), 1'b1);
    w = 1'b1; F = 3'b001; Rx = y; Data = 16'h0099;
    step();
    w = 1'b0;
    check("drop t3 done", done(), 1'b1);
    check("drop t3 bus", bus(), sum);
    step();
    check("drop rx", rd(x), sum);
    check("drop ry", rd(y), vb);
    check("drop carry", carry(), 1'b1);
    check("drop idle", busy(), 1'b0);
    mvi(x, va);
    w = 1'b1; F = 3'b010; Rx = x; Ry = y;
    step();
    w = 1'b0;
    step();
    Reset = 1'b1;
    w = 1'b1;
    step();
    Reset = 1'b0;
    w = 1'b0;
    check("abort rx", rd(x), 16'h0000);
    check("abort ry", rd(y), 16'h0000);
    check("abort busy", busy(), 1'b0);
    check("abort done", done(), 1'b0);
    check("abort bus", bus(), 16'h0000);
    check("abort flags", {carry(), zero()}, 2'b00);
    step();
    check("abort w ignored", busy(), 1'b0);
  endtask

  initial begin
    Reset = 1'b1; w = 1'b0; Data = '0; F = '0; Rx = '0; Ry = '0;
    step();
    step();
    Reset = 1'b0;
    check("rst busy", busy(), 1'b0);
    check("rst done", done(), 1'b0);
    check("rst bus", bus(), 16'h0000);
    check("rst flags", {carry(), zero()}, 2'b00);
    for (int i = 0; i < 4; i++) check("rst reg", rd(3'(i)), 16'h0000);

    run("mvi r1", 3'b001, 3'd1, 3'd0, 16'h005A, 1);
    check("mvi bus", bq[0], 16'h005A);
    check("mvi r1 val", rd(3'd1), 16'h005A);
    run("mv r3", 3'b000, 3'd3, 3'd1, 16'h0000, 1);
    check("mv bus", bq[0], 16'h005A);
    check("mv r3 val", rd(3'd3), 16'h005A);

    mvi(3'd0, 16'h00F0);
    mvi(3'd1, 16'h0020);
    run("add", 3'b010, 3'd0, 3'd1, 16'h0000, 3);
    check("add bus t1", bq[0], 16'h00F0);
    check("add bus t2", bq[1], 16'h0020);
    check("add bus t3", bq[2], 16'h0010);
    check("add r0", rd(3'd0), 16'h0010);
    check("add cz", {carry(), zero()}, 2'b10);

    mvi(3'd2, 16'h0033);
    run("sub self", 3'b011, 3'd2, 3'd2, 16'h0000, 3);
    check("sub self r2", rd(3'd2), 16'h0000);
    check("sub self cz", {carry(), zero()}, 2'b11);
    mvi(3'd0, 16'h0001);
    mvi(3'd1, 16'h0002);
    run("sub borrow", 3'b011, 3'd0, 3'd1, 16'h0000, 3);
    check("sub borrow r0", rd(3'd0), 16'h00FF);
    check("sub borrow cz", {carry(), zero()}, 2'b00);

    mvi(3'd0, 16'h00C3);
    mvi(3'd1, 16'h000F);
    run("and", 3'b100, 3'd0, 3'd1, 16'h0000, 3);
    check("and r0", rd(3'd0), 16'h0003);
    check("and cz", {carry(), zero()}, 2'b00);
    mvi(3'd0, 16'h00C3);
    run("or", 3'b101, 3'd0, 3'd1, 16'h0000, 3);
    check("or r0", rd(3'd0), 16'h00CF);
    check("or cz", {carry(), zero()}, 2'b00);
    mvi(3'd0, 16'h00C3);
    run("xor", 3'b110, 3'd0, 3'd1, 16'h0000, 3);
    check("xor r0", rd(3'd0), 16'h00CC);
    check("xor cz", {carry(), zero()}, 2'b00);

    mvi(3'd0, 16'h0081);
    run("shr", 3'b111, 3'd0, 3'd1, 16'h0000, 3);
    check("shr r0", rd(3'd0), 16'h0040);
    check("shr cz", {carry(), zero()}, 2'b10);
    run("mv keep", 3'b000, 3'd2, 3'd0, 16'h0000, 1);
    check("mv keep r2", rd(3'd2), 16'h0040);
    check("mv keep cz", {carry(), zero()}, 2'b10);
    mvi(3'd1, 16'h0001);
    run("shr zero", 3'b111, 3'd1, 3'd1, 16'h0000, 3);
    check("shr zero r1", rd(3'd1), 16'h0000);
    check("shr zero cz", {carry(), zero()}, 2'b11);

    abort_test(3'd0, 3'd1, 16'h00F0, 16'h0020, 16'h0010);

    s16 = 1'b1;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    mvi(3'd7, 16'h8001);
    mvi(3'd6, 16'h8000);
    run("add16", 3'b010, 3'd7, 3'd6, 16'h0000, 3);
    check("add16 bus t1", bq[0], 16'h8001);
    check("add16 bus t2", bq[1], 16'h8000);
    check("add16 bus t3", bq[2], 16'h0001);
    check("add16 r7", rd(3'd7), 16'h0001);
    check("add16 cz", {carry(), zero()}, 2'b10);
    abort_test(3'd7, 3'd6, 16'h8001, 16'h8000, 16'h0001);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule

// File: doc/proc_gen.md
# proc_gen

Parametrised successor to the four-register multicycle processor. Accepts one instruction per `w` pulse. The instruction selects a function code `F` and register fields `Rx`/`Ry`. It executes move, move-immediate, four arithmetic/logic operations and a shift over a shared bus, using a 2-bit step counter (T0–T3). Compared with the previous generation it adds:
- configurable data width and register count
- AND/OR/XOR/SHR operations
- registered Carry/Zero flags
- a Busy output

## Interface
- `N`, 8: data/bus/register width in bits (N ≥ 2).
- `RB`, 2: register-select width; register file holds 2^RB registers R0..R(2^RB−1).
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `w`  in  1  start strobe, sampled only in T0.
- `Data`  in  N  immediate operand for mvi, sampled in T1.
- `F`  in  3  function code, sampled with `w` in T0.
- `Rx`  in  RB  destination / first operand, sampled with `w` in T0.
- `Ry`  in  RB  source / second operand, sampled with `w` in T0.
- `BusWires`  out  N  shared bus value.
- `Done`  out  1  high during the final step of an instruction.
- `Busy`  out  1  high whenever the step counter is not in T0.
- `Carry`  out  1  registered carry flag.
- `Zero`  out  1  registered zero flag.

## Operation
- Function codes:
  - 000 mv: Rx←Ry
  - 001 mvi: Rx←Data
  - 010 add: Rx←Rx+Ry
  - 011 sub: Rx←Rx−Ry
  - 100 and
  - 101 or
  - 110 xor
  - 111 shr: Rx←Rx>>1 (logical; Ry ignored)
- Step counter: T0 → T1 → T2 → T3. It clears to T0 on `Reset`, on `Done`, or when in T0 with `w`=0.
- Function register (F, Rx, Ry; 3+2·RB bits) loads when `w`=1 in T0. `F`, `Rx`, `Ry` and `w` are ignored in every other step.
- mv/mvi are one-step instructions:
  - T1 mv: Ry drives bus, Rx loads from bus, `Done`=1.
  - T1 mvi: `Data` drives bus, Rx loads from bus, `Done`=1.
- ALU ops (codes 010–111) take three steps:
  - T1: Rx drives bus; A loads from bus.
  - T2: Ry drives bus; G loads the ALU result; flags update.
  - T3: G drives bus; Rx loads from bus; `Done`=1.
- Arithmetic is N-bit modulo 2^N.
  - add: Carry = carry-out of A+Bus.
  - sub: computed as A+~Bus+1; Carry = carry-out, i.e. 1 iff A ≥ Bus unsigned.
  - and/or/xor: Carry←0.
  - shr: Carry←A[0], result MSB = 0.
  - Zero←(result==0) for every ALU op.
- mv/mvi leave the flags unchanged.
- Bus driver priority (exactly one or none): Extern, G, register. With no driver active, `BusWires`=0.
- Rx=Ry is legal for all codes: e.g. sub with Rx=Ry gives 0, Zero=1, Carry=1.

## Timing
- Reset (synchronous) takes effect at the rising edge where `Reset`=1. After it:
  - all registers, A, G and the function register = 0
  - Carry = Zero = 0
  - counter = T0
  - `Done`=0, `Busy`=0, `BusWires`=0
- Reset asserted mid-instruction aborts it: no register write occurs at that edge, and the flags are cleared, not updated.
- `Done` and `Busy` are combinational from the counter and the function register. Register writes happen on the edge that ends the `Done` cycle.
- Latency from the `w` edge: mv/mvi 2 cycles to the Rx update; ALU ops 4 cycles.
- Back-to-back issue: the counter is in T0 on the cycle after `Done`, so `w` held high issues the next instruction immediately.
- `w` pulses while `Busy`=1 are dropped and never queued.
- A source register written by instruction k is visible to instruction k+1.

## Test plan
- Reset: from arbitrary state, assert `Reset` one cycle. Required: all registers 0, flags 0, `Busy`=0, `BusWires`=0. A `w` in the same cycle as `Reset` is ignored.
- mvi/mv (N=8, RB=2):
  - mvi R1,0x5A → `Done` in T1, R1=0x5A.
  - then mv R3,R1 → R3=0x5A; `Busy` high exactly one cycle per instruction.
- add carry: R0=0xF0, R1=0x20; add R0,R1 → `Done` in T3, R0=0x10, Carry=1, Zero=0. Bus sequence over T1..T3 = 0xF0, 0x20, 0x10.
- sub/zero and borrow:
  - sub R2,R2 with R2=0x33 → R2=0, Zero=1, Carry=1.
  - then with R0=0x01, R1=0x02: sub R0,R1 → R0=0xFF, Carry=0.
- logic/shift:
  - R0=0xC3, R1=0x0F: and → 0x03, or → 0xCF, xor → 0xCC, each with Carry=0.
  - shr on R0=0x81 → 0x40, Carry=1.
  - mv afterwards leaves the flags unchanged.
- Abort and busy-drop:
  - `w` pulse in T2 of an add → no effect; add completes normally.
  - `Reset` in T2 of an add → Rx unchanged (0 after reset), counter in T0 next cycle.
  - Repeat with N=16, RB=3 using R7 as destination.
